// File: rtl/rfile_warb.sv
// rfile_warb: two-requester arbiter for a single register-file write port.
// Define RFILE_WARB_RR_EN for round-robin tie-break; otherwise requester 0 always wins ties.
module rfile_warb #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_valid_i,
   input  logic [4:0]       req0_addr_i,
   input  logic [31:0]      req0_data_i,
   output logic             req0_ready_o,
   input  logic             req1_valid_i,
   input  logic [4:0]       req1_addr_i,
   input  logic [31:0]      req1_data_i,
   output logic             req1_ready_o,
   output logic             reg_write_o,
   output logic [4:0]       w_addr_o,
   output logic [31:0]      w_data_o,
   output logic             last_grant_o,
   output logic [CNT_W-1:0] conflict_cnt_o
);
   logic             gnt0, gnt1, xfer, pri0;
   logic [4:0]       addr_sel;
   logic [31:0]      data_sel;
   logic             reg_write_q, reg_write_d, last_grant_q, last_grant_d;
   logic [4:0]       w_addr_q, w_addr_d;
   logic [31:0]      w_data_q, w_data_d;
   logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
`ifdef RFILE_WARB_RR_EN
   typedef enum logic {PRI0, PRI1} pri_e;
   pri_e pri_q, pri_d;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) pri_q <= PRI0;
      else       pri_q <= pri_d;
   always_comb begin
      pri_d = gnt0 ? PRI1 : (gnt1 ? PRI0 : pri_q);
   end
   assign pri0 = (pri_q == PRI0);
`else
   assign pri0 = 1'b1;
`endif
   always_comb begin
      // readies are held low while reset is asserted
      gnt0           = ~rst_i & req0_valid_i & (~req1_valid_i | pri0);
      gnt1           = ~rst_i & req1_valid_i & ~gnt0;
      xfer           = gnt0 | gnt1;
      addr_sel       = gnt1 ? req1_addr_i : req0_addr_i;
      data_sel       = gnt1 ? req1_data_i : req0_data_i;
      reg_write_d    = xfer & (addr_sel != 5'd0);
      w_addr_d       = reg_write_d ? addr_sel : w_addr_q;
      w_data_d       = reg_write_d ? data_sel : w_data_q;
      last_grant_d   = xfer ? gnt1 : last_grant_q;
      conflict_cnt_d = (req0_valid_i & req1_valid_i & ~&conflict_cnt_q) ? conflict_cnt_q + 1'b1 : conflict_cnt_q;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         reg_write_q    <= 1'b0;
         w_addr_q       <= '0;
         w_data_q       <= '0;
         last_grant_q   <= 1'b0;
         conflict_cnt_q <= '0;
      end else begin
         reg_write_q    <= reg_write_d;
         w_addr_q       <= w_addr_d;
         w_data_q       <= w_data_d;
         last_grant_q   <= last_grant_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   assign req0_ready_o   = gnt0;
   assign req1_ready_o   = gnt1;
   assign reg_write_o    = reg_write_q;
   assign w_addr_o       = w_addr_q;
   assign w_data_o       = w_data_q;
   assign last_grant_o   = last_grant_q;
   assign conflict_cnt_o = conflict_cnt_q;
endmodule

// File: tb/tb_rfile_warb.sv
// tb_rfile_warb: randomized and directed checks of rfile_warb against a transaction-level model.
module tb_rfile_warb;
`ifdef RFILE_WARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic r0v = 0, r1v = 0, r0r, r1r, we, lg;
   logic [4:0] r0a = 0, r1a = 0, wa;
   logic [31:0] r0d = 0, r1d = 0, wd;
   logic [CW-1:0] cc;
   rfile_warb #(.CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(r0v), .req0_addr_i(r0a), .req0_data_i(r0d), .req0_ready_o(r0r),
      .req1_valid_i(r1v), .req1_addr_i(r1a), .req1_data_i(r1d), .req1_ready_o(r1r),
      .reg_write_o(we), .w_addr_o(wa), .w_data_o(wd), .last_grant_o(lg), .conflict_cnt_o(cc)
   );
   int n_chk = 0, n_pass = 0;
   int m_tie = 0, m_cnt = 0;
   bit m_we = 0, m_lg = 0;
   logic [4:0] m_addr = 0;
   logic [31:0] m_data = 0;
   logic [31:0] m_rf [32];
   logic [31:0] d_rf [32];
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic model_reset();
      m_tie = 0; m_cnt = 0; m_we = 0; m_lg = 0; m_addr = 0; m_data = 0;
   endtask
   task automatic check_outs();
      chk("reg_write", we, m_we);
      chk("w_addr", wa, m_addr);
      chk("w_data", wd, m_data);
      chk("last_grant", lg, m_lg);
      chk("conflict_cnt", cc, m_cnt);
   endtask
   // one cycle: drive requests, check grants, advance model, check registered outputs
   task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                       output bit g0, output bit g1);
      int w;
      logic [4:0] a;
      logic [31:0] d;
      r0v = v0; r0a = a0; r0d = d0; r1v = v1; r1a = a1; r1d = d1;
      #2;
      w = (v0 && v1) ? m_tie : (v0 ? 0 : (v1 ? 1 : -1));
      g0 = (w == 0);
      g1 = (w == 1);
      chk("req0_ready", r0r, g0);
      chk("req1_ready", r1r, g1);
      m_we = 0;
      if (w >= 0) begin
         a = (w == 1) ? a1 : a0;
         d = (w == 1) ? d1 : d0;
         m_lg = (w == 1);
         if (a != 0) begin
            m_we = 1; m_addr = a; m_data = d; m_rf[a] = d;
         end
         if (RR) m_tie = 1 - w;
      end
      if (v0 && v1 && m_cnt < CMAX) m_cnt++;
      @(posedge clk); #1;
      if (we) d_rf[wa] = wd;
      check_outs();
   endtask
   initial begin
      bit g0, g1, p0, p1;
      logic [4:0] a0, a1;
      logic [31:0] d0, d1;
      for (int i = 0; i < 32; i++) begin m_rf[i] = 0; d_rf[i] = 0; end
      #2;
      check_outs();
      chk("rst_ready0", r0r, 1'b0);
      @(posedge clk); #1;
      rst = 0;
      step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, g0, g1);
      step(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, g0, g1);
      step(0, 0, 0, 0, 0, 0, g0, g1);
      p0 = 1; p1 = 1;
      repeat (3) begin
         step(p0, 5'd3, 32'h11, p1, 5'd4, 32'h22, g0, g1);
         if (g0) p0 = 0;
         if (g1) p1 = 0;
      end
      chk("conflict_after_pair", cc, 4'd1);
      chk("reg3", d_rf[3], 32'h11);
      chk("reg4", d_rf[4], 32'h22);
      repeat (4) step(1, 5'd6, 32'h66, 1, 5'd7, 32'h77, g0, g1);
      repeat (17) step(1, 5'd8, $urandom, 1, 5'd8, $urandom, g0, g1);
      chk("conflict_sat", cc, CMAX);
      p0 = 0; p1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
      repeat (400) begin
         if (!p0 && $urandom_range(0, 3) != 0) begin p0 = 1; a0 = 5'($urandom_range(0, 7)); d0 = $urandom; end
         if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; a1 = 5'($urandom_range(0, 7)); d1 = $urandom; end
         step(p0, a0, d0, p1, a1, d1, g0, g1);
         if (g0) p0 = 0;
         if (g1) p1 = 0;
      end
      for (int i = 1; i < 32; i++) chk($sformatf("rf%0d", i), d_rf[i], m_rf[i]);
      step(1, 5'd10, 32'hA5A5A5A5, 0, 0, 0, g0, g1);
      r0v = 0; r1v = 1; r1a = 5'd9; r1d = 32'hCAFEF00D;
      #2;
      chk("pre_rst_ready1", r1r, 1'b1);
      rst = 1;
      #1;
      model_reset();
      check_outs();
      chk("rst_ready1", r1r, 1'b0);
      @(posedge clk); #1;
      check_outs();
      r1v = 0;
      rst = 0;
      step(0, 0, 0, 0, 0, 0, g0, g1);
      step(1, 5'd2, 32'h2222, 1, 5'd3, 32'h3333, g0, g1);
      step(0, 0, 0, 1, 5'd3, 32'h3333, g0, g1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
